// File: rtl/t07_esp_rx.sv
// Quad-SPI receiver from the ESP32: synchronises the ESP pins, assembles
// MSB-first 32-bit words and buffers them in a first-word fall-through FIFO.
module t07_esp_rx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     esp_sclk_i,
    input  logic                     esp_cs_n_i,
    input  logic [3:0]               esp_data_i,
    input  logic                     rd_i,
    input  logic                     clr_i,
    output logic [31:0]              data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     frame_err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic       sclk_s1, sclk_s2, sclk_s3;
    logic       cs_s1, cs_s2;
    logic [3:0] data_s1, data_s2;
    logic [1:0] settle;
    logic       rise;

    // Only the last seven nibbles are kept; the eighth comes straight from the synchroniser.
    logic [27:0] shift;
    logic [2:0]  nib_cnt;
    logic        shift_en, cnt_clr, push, frame_set;
    logic [31:0] word;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en, ovf_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            data_s1 <= 4'h0;
            data_s2 <= 4'h0;
            settle  <= 2'b00;
        end else begin
            sclk_s1 <= esp_sclk_i;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= esp_cs_n_i;
            cs_s2   <= cs_s1;
            data_s1 <= esp_data_i;
            data_s2 <= data_s1;
            settle  <= {settle[0], 1'b1};
        end
    end

    assign rise = sclk_s2 & ~sclk_s3;
    assign word = {shift, data_s2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= WAIT_HIGH;
        else     state_q <= state_d;
    end

    // After reset cs_s2 only reflects the pin once settle[1] is set, so a
    // frame already in progress is locked out until cs_n is seen high.
    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            WAIT_HIGH: if (settle[1] && cs_s2) state_d = IDLE;
            IDLE:      if (!cs_s2) state_d = SHIFT;
            SHIFT: begin
                if (cs_s2) begin
                    state_d   = IDLE;
                    cnt_clr   = 1'b1;
                    frame_set = (nib_cnt != 3'd0);
                end else if (rise) begin
                    shift_en = 1'b1;
                    push     = (nib_cnt == 3'd7);
                end
            end
            default:   state_d = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            nib_cnt <= 3'd0;
        end else if (cnt_clr) begin
            shift   <= '0;
            nib_cnt <= 3'd0;
        end else if (shift_en) begin
            shift   <= {shift[23:0], data_s2};
            nib_cnt <= nib_cnt + 3'd1;
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = rd_i & ~empty;
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            overflow_o  <= ovf_set   | (overflow_o  & ~clr_i);
            frame_err_o <= frame_set | (frame_err_o & ~clr_i);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= word;
    end

    assign valid_o = ~empty;
    assign full_o  = full;
    assign count_o = wr_ptr - rd_ptr;
    assign data_o  = valid_o ? mem[rd_ptr[AW-1:0]] : 32'h0;

endmodule

// File: tb/tb_t07_esp_rx.sv
// Self-checking bench for t07_esp_rx: directed test-plan steps plus random
// frames, compared against a queue-based model of the word stream.
module tb_t07_esp_rx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, esp_sclk_i, esp_cs_n_i, rd_i, clr_i;
    logic [3:0]  esp_data_i;
    logic [31:0] data_o;
    logic        valid_o, full_o, overflow_o, frame_err_o;
    logic [$clog2(DEPTH):0] count_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_q[$];
    bit          model_ovf, model_ferr;

    t07_esp_rx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .esp_sclk_i(esp_sclk_i), .esp_cs_n_i(esp_cs_n_i), .esp_data_i(esp_data_i),
        .rd_i(rd_i), .clr_i(clr_i),
        .data_o(data_o), .valid_o(valid_o), .full_o(full_o), .count_o(count_o),
        .overflow_o(overflow_o), .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, ".data"},  data_o, (model_q.size() > 0) ? model_q[0] : 32'h0);
        check({tag, ".valid"}, 32'(valid_o), 32'(model_q.size() > 0));
        check({tag, ".full"},  32'(full_o), 32'(model_q.size() == DEPTH));
        check({tag, ".count"}, 32'(count_o), 32'(model_q.size()));
        check({tag, ".ovf"},   32'(overflow_o), 32'(model_ovf));
        check({tag, ".ferr"},  32'(frame_err_o), 32'(model_ferr));
    endtask

    // A completed word: an accompanying pop frees a slot first; a set wins over clear.
    task automatic model_push(input logic [31:0] w, input bit rd, input bit clr);
        bit ev = 0;
        if (rd && model_q.size() > 0) void'(model_q.pop_front());
        if (model_q.size() < DEPTH) model_q.push_back(w);
        else ev = 1;
        if (ev) model_ovf = 1;
        else if (clr) model_ovf = 0;
        if (clr) model_ferr = 0;
    endtask

    task automatic send_nibble(input logic [3:0] n);
        esp_data_i = n;
        tick(3);
        esp_sclk_i = 1'b1;
        tick(3);
        esp_sclk_i = 1'b0;
    endtask

    // The last nibble can carry rd_i/clr_i in the exact cycle the word is pushed.
    task automatic send_word(input logic [31:0] w, input bit last_rd, input bit last_clr);
        logic [31:0] v = w;
        for (int i = 0; i < 7; i++) send_nibble(v[31-4*i -: 4]);
        esp_data_i = v[3:0];
        tick(3);
        esp_sclk_i = 1'b1;
        tick(2);
        rd_i  = last_rd;
        clr_i = last_clr;
        tick(1);
        rd_i  = 1'b0;
        clr_i = 1'b0;
        tick(1);
        esp_sclk_i = 1'b0;
        model_push(w, last_rd, last_clr);
    endtask

    task automatic frame_begin();
        esp_cs_n_i = 1'b0;
        tick(2);
    endtask

    task automatic frame_end(input int nibbles_sent);
        tick(2);
        esp_cs_n_i = 1'b1;
        tick(4);
        if (nibbles_sent % 8 != 0) model_ferr = 1;
    endtask

    task automatic pop_word(input string tag);
        rd_i = 1'b1;
        tick(1);
        rd_i = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        check_output(tag);
    endtask

    task automatic clear_flags();
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        model_ovf  = 0;
        model_ferr = 0;
    endtask

    initial begin
        logic [31:0] w;
        int nw, np, nb;

        rst = 1'b1; esp_sclk_i = 1'b0; esp_cs_n_i = 1'b1; esp_data_i = 4'h0;
        rd_i = 1'b0; clr_i = 1'b0;
        model_ovf = 0; model_ferr = 0;
        tick(3);
        check_output("reset");
        rst = 1'b0;
        tick(4);
        check_output("post_reset");

        // Single word with exact latency from the s1 capture of the 8th rise.
        frame_begin();
        w = 32'hDEADBEEF;
        for (int i = 0; i < 7; i++) send_nibble(w[31-4*i -: 4]);
        esp_data_i = 4'hF;
        tick(3);
        esp_sclk_i = 1'b1;
        @(posedge clk); #1;
        check("lat_k.valid", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        check("lat_k1.valid", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        check("lat_k2.valid", 32'(valid_o), 32'd1);
        check("lat_k2.data", data_o, 32'hDEADBEEF);
        check("lat_k2.count", 32'(count_o), 32'd1);
        @(negedge clk);
        tick(1);
        esp_sclk_i = 1'b0;
        model_push(w, 0, 0);
        frame_end(8);
        check_output("single");
        pop_word("single_pop");
        pop_word("pop_empty");

        // Burst of five words into a four-entry FIFO.
        frame_begin();
        for (int i = 1; i <= 5; i++) send_word(32'(i), 0, 0);
        frame_end(40);
        check_output("burst");
        for (int i = 0; i < 4; i++) pop_word("burst_pop");
        clear_flags();
        check_output("burst_clr");

        // Frame error then a clean word.
        frame_begin();
        for (int i = 0; i < 3; i++) send_nibble(4'(i + 7));
        frame_end(3);
        check_output("frame_err");
        frame_begin();
        send_word(32'h12345678, 0, 0);
        frame_end(8);
        check_output("after_ferr");
        pop_word("after_ferr_pop");
        clear_flags();
        check_output("ferr_clr");

        // Push and pop in the same cycle while full.
        frame_begin();
        for (int i = 0; i < 4; i++) send_word($urandom, 0, 0);
        send_word(32'hCAFEF00D, 1, 0);
        frame_end(40);
        check_output("push_pop_full");
        for (int i = 0; i < 3; i++) pop_word("pp_pop");
        check("pp_last", data_o, 32'hCAFEF00D);
        pop_word("pp_drain");

        // Reset mid-word: the rest of that frame must be ignored.
        frame_begin();
        for (int i = 0; i < 5; i++) send_nibble(4'hC);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_q.delete();
        model_ovf = 0;
        model_ferr = 0;
        check_output("mid_rst");
        for (int i = 0; i < 3; i++) send_nibble(4'h3);
        check_output("mid_rst_cont");
        frame_end(0);
        check_output("mid_rst_end");
        frame_begin();
        send_word(32'hA5A5A5A5, 0, 0);
        frame_end(8);
        check_output("a5_frame");
        pop_word("a5_pop");

        // Clear in the same cycle as an overflow: the set wins.
        frame_begin();
        for (int i = 0; i < 4; i++) send_word($urandom, 0, 0);
        send_word(32'h0BADF00D, 0, 1);
        frame_end(40);
        check_output("clr_vs_ovf");
        for (int i = 0; i < 4; i++) pop_word("cv_pop");
        clear_flags();
        check_output("cv_clr");

        // Random frames, partial words, pops and clears.
        for (int it = 0; it < 8; it++) begin
            nw = int'($urandom_range(1, 3));
            np = int'($urandom_range(0, 3));
            frame_begin();
            for (int i = 0; i < nw; i++) send_word($urandom, bit'($urandom_range(0, 1)), 0);
            nb = (np == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int i = 0; i < nb; i++) send_nibble(4'($urandom));
            frame_end(nb);
            check_output("rnd_frame");
            for (int i = 0; i < np; i++) pop_word("rnd_pop");
            if ($urandom_range(0, 2) == 0) begin
                clear_flags();
                check_output("rnd_clr");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
